// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a read-valid strobe. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = 12,
   parameter int AE_THRESH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   output logic                       wr_full,
   output logic                       wr_almost_full,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic                       rd_empty,
   output logic                       rd_almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] AF_LVL  = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_LVL  = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_acc_s;
   logic          rd_acc_s;

   // Accept decisions, pointer advance and occupancy bookkeeping
   always_comb begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (wr_en && !full_q) begin
         wr_acc_s = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_acc_s = 1'b0;
      end

      if (rd_en && !empty_q) begin
         rd_acc_s = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_acc_s = 1'b0;
      end

      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Status flags derived from next-state pointers/occupancy so they never lag
   always_comb begin
      full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
      empty_d = (wr_ptr_d == rd_ptr_d);
      af_d    = (count_d >= AF_LVL);
      ae_d    = (count_d <= AE_LVL);
   end

   // Sticky error flags; a fresh error in the clearing cycle keeps the flag set
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;

      if (wr_en && full_q) begin
         ovf_d = 1'b1;
      end else if (err_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (rd_en && empty_q) begin
         unf_d = 1'b1;
      end else if (err_clr) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // Control and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head entry falls through; rd_en only acknowledges it
   assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_valid = !empty_q;
`else
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   // Registered read: popped word appears with a one-cycle valid strobe
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc_s) begin
         rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
         rd_valid_d = 1'b1;
      end else begin
         rd_data_d  = rd_data_q;
         rd_valid_d = 1'b0;
      end
   end

   // Read data/valid registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= {DATA_WIDTH{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

   assign wr_full         = full_q;
   assign wr_almost_full  = af_q;
   assign rd_empty        = empty_q;
   assign rd_almost_empty = ae_q;
   assign count           = count_q;
   assign overflow        = ovf_q;
   assign underflow       = unf_q;

endmodule
